fir_coeff_reload_src: RTL
=========================

// Module: fir_coeff_reload_src
// PURPOSE
//  Coefficient reload transmitter for fir_filter_iq: holds a symmetric-FIR half-table and streams it
//  over the filter's reload interface (coeff_in/reload_tvalid/reload_tlast) with AXI-stream handshake.
//  Sits between the control/register domain and the FIR; replaces ad-hoc bench/driver reload logic.
// PARAMETERS
//  COEFF_WIDTH  16                      coefficient width, bits
//  NUM_COEFFS   128                     FIR taps (even); table holds H = NUM_COEFFS/2 entries
//  ADDR_WIDTH   6                       table index width, = clog2(NUM_COEFFS/2)
//  COEFFS_VEC   0 ((NUM_COEFFS/2)*COEFF_WIDTH bits)  reset contents; entry k = COEFFS_VEC[k*COEFF_WIDTH +: COEFF_WIDTH]
//  AUTO_LOAD    1                       1: start one stream automatically after reset release
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous reset, active-high
//  wr_en          in   1            table write strobe
//  wr_addr        in   ADDR_WIDTH   table write index (0..H-1)
//  wr_data        in   COEFF_WIDTH  table write data
//  start          in   1            request one reload stream (pulse)
//  reload_tdata   out  COEFF_WIDTH  coefficient to FIR coeff_in
//  reload_tvalid  out  1            beat valid
//  reload_tlast   out  1            final beat of stream
//  reload_tready  in   1            FIR accepts beat
//  busy           out  1            stream in progress
//  done           out  1            one-cycle pulse, stream completed
// BEHAVIOUR
//  - Reset (async assert, sync release): table <= COEFFS_VEC; state IDLE; reload_tdata=0, reload_tvalid=0,
//    reload_tlast=0, busy=0, done=0; beat counter=0. AUTO_LOAD=1 arms a start for first cycle after release.
//  - FSM: IDLE -(start|auto)-> STREAM -(handshake on last beat)-> DONE -> IDLE (DONE lasts exactly 1 cycle, done=1).
//  - Latency: start sampled in cycle n -> reload_tvalid=1, busy=1, beat 0 on outputs in cycle n+1 (registered).
//  - Handshake: beat transfers when reload_tvalid & reload_tready; tdata/tlast held stable while
//    tvalid & !tready; tvalid never drops mid-stream; next beat presented the cycle after a transfer.
//  - Beat order: table index 0,1,..,H-1; reload_tlast=1 only on beat H-1 (see macro for mirrored mode).
//  - After last transfer: tvalid=0, tlast=0, busy=0 next cycle, done=1 that cycle; tdata holds last value.
//  - start while busy or in DONE: ignored (no queuing). start and final handshake same cycle: start ignored.
//  - wr_en while busy: ignored, table unchanged (stream contents are atomic). wr_en in IDLE/DONE: write
//    takes effect next cycle; wr_en and start same cycle in IDLE: write applied first, stream sends new value.
//  - wr_addr >= H (non power-of-two H): write dropped.
//  - reset mid-stream: outputs return to reset values immediately, no tlast emitted, no done pulse;
//    table reloads COEFFS_VEC.
//  - Counter wraps only via FSM; no arithmetic on data (pass-through, no sign handling).
// CONFIGURATION
//  FIR_RELOAD_MIRROR_EN defined: stream full NUM_COEFFS beats: indices 0..H-1 then H-1..0 (symmetric
//    expansion for non-symmetric-aware FIR builds); reload_tlast on final beat (index 0, beat NUM_COEFFS-1);
//    counter one bit wider.
//  Not defined: H beats only, as above (matches fir_filter_iq symmetric reload).
// TESTING
//  1. Reset, COEFFS_VEC entries k=k+1, AUTO_LOAD=1, tready=1 -> beats 1..64 on consecutive cycles, tlast on 64th,
//     done pulse 1 cycle later-equal to busy fall.
//  2. tready toggled 1-0-0-1 pattern -> tdata/tlast stable while stalled; exactly 64 transfers, no dup/skip.
//  3. IDLE: wr_en addr 5 data 0xBEEF then start -> beat 5 = 0xBEEF; write addr 6 during stream -> ignored,
//     next stream still shows old entry 6.
//  4. start pulsed at beat 10 and on last handshake cycle -> ignored; single 64-beat stream, one done pulse.
//  5. reset asserted at beat 30 -> tvalid/tlast/busy/done 0 same cycle; table back to COEFFS_VEC; AUTO_LOAD restream.
//  6. FIR_RELOAD_MIRROR_EN, table k+1 -> 128 beats 1..64,64..1, tlast only on beat 128 (value 1).

Source files
------------

// File: rtl/fir_coeff_reload_src.sv
// ============================================================================
// Module   : fir_coeff_reload_src
// Purpose  : Holds a symmetric-FIR half coefficient table and streams it to the
//            FIR reload port with a valid/ready handshake.
//            Optional macro FIR_RELOAD_MIRROR_EN: stream 0..H-1 then H-1..0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_coeff_reload_src #(
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_COEFFS  = 128,
   parameter int ADDR_WIDTH  = 6,
   parameter logic [(NUM_COEFFS/2)*COEFF_WIDTH-1:0] COEFFS_VEC = '0,
   parameter int AUTO_LOAD   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [COEFF_WIDTH-1:0] wr_data,
   input  logic                   start,
   output logic [COEFF_WIDTH-1:0] reload_tdata,
   output logic                   reload_tvalid,
   output logic                   reload_tlast,
   input  logic                   reload_tready,
   output logic                   busy,
   output logic                   done
);

   localparam int H = NUM_COEFFS / 2;
`ifdef FIR_RELOAD_MIRROR_EN
   localparam int CNT_W  = ADDR_WIDTH + 1;
   localparam int NBEATS = NUM_COEFFS;
`else
   localparam int CNT_W  = ADDR_WIDTH;
   localparam int NBEATS = H;
`endif
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NBEATS - 1);
   localparam logic [ADDR_WIDTH:0] H_EXT    = (ADDR_WIDTH + 1)'(H);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]             state_q,  state_d;
   logic [CNT_W-1:0]       cnt_q,    cnt_d;
   logic [COEFF_WIDTH-1:0] coeff_q [H];
   logic [COEFF_WIDTH-1:0] coeff_d [H];
   logic                   auto_q,   auto_d;
   logic [COEFF_WIDTH-1:0] tdata_q,  tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q,  tlast_d;
   logic                   busy_q,   busy_d;
   logic                   done_q,   done_d;

   logic                   wr_ok;
   logic [CNT_W-1:0]       rd_cnt;
   logic [CNT_W-1:0]       next_cnt;
   logic [ADDR_WIDTH-1:0]  rd_idx;
   logic [COEFF_WIDTH-1:0] rd_data;

   // Reads use the post-write table so a write and start in the same cycle stream the new value.
   always_comb begin
      wr_ok   = wr_en && (state_q != ST_STREAM) && ({1'b0, wr_addr} < H_EXT);
      coeff_d = coeff_q;
      if (wr_ok) begin
         coeff_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      next_cnt = cnt_q + CNT_W'(1);
      rd_cnt   = (state_q == ST_STREAM) ? next_cnt : '0;
`ifdef FIR_RELOAD_MIRROR_EN
      if (rd_cnt < CNT_W'(H)) begin
         rd_idx = rd_cnt[ADDR_WIDTH-1:0];
      end else begin
         rd_idx = ADDR_WIDTH'(CNT_W'(NUM_COEFFS - 1) - rd_cnt);
      end
`else
      rd_idx = rd_cnt;
`endif
      rd_data = coeff_d[rd_idx];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      auto_d   = 1'b0;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start || auto_q) begin
               state_d  = ST_STREAM;
               cnt_d    = '0;
               tdata_d  = rd_data;
               tvalid_d = 1'b1;
               tlast_d  = (LAST_CNT == '0);
               busy_d   = 1'b1;
            end
         end
         ST_STREAM: begin
            if (tvalid_q && reload_tready) begin
               if (cnt_q == LAST_CNT) begin
                  state_d  = ST_DONE;
                  cnt_d    = '0;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  cnt_d   = next_cnt;
                  tdata_d = rd_data;
                  tlast_d = (next_cnt == LAST_CNT);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         auto_q   <= (AUTO_LOAD != 0);
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int k = 0; k < H; k++) begin
            coeff_q[k] <= COEFFS_VEC[k*COEFF_WIDTH +: COEFF_WIDTH];
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         auto_q   <= auto_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         coeff_q  <= coeff_d;
      end
   end

   assign reload_tdata  = tdata_q;
   assign reload_tvalid = tvalid_q;
   assign reload_tlast  = tlast_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

`default_nettype wire
